// File: rtl/munoc_monitor_pkg.sv
// -----------------------------------------------------------------------------
// munoc_monitor_pkg
//
// Shared constants for the AXI protocol-monitor status collector:
//   - APB byte offsets of the six mapped registers (STATUS .. EVENT_COUNT)
//   - FIRST register layout (valid-bit position, index field width)
//   - reg_sel(): maps a byte address onto the 3-bit register select used by
//     the decoder, so offsets and decode can never drift apart.
// -----------------------------------------------------------------------------
package munoc_monitor_pkg;

    // Register byte offsets; bits [4:2] select the register, [1:0] ignored.
    localparam logic [4:0] OFF_STATUS      = 5'h00;
    localparam logic [4:0] OFF_CLEAR       = 5'h04;
    localparam logic [4:0] OFF_MASK        = 5'h08;
    localparam logic [4:0] OFF_FIRST       = 5'h0C;
    localparam logic [4:0] OFF_TIMESTAMP   = 5'h10;
    localparam logic [4:0] OFF_EVENT_COUNT = 5'h14;

    // FIRST register layout.
    localparam int FIRST_VALID_BIT = 31;
    localparam int FIRST_IDX_W     = 8;

    // CLEAR[31] wipes FIRST.valid, TIMESTAMP and EVENT_COUNT.
    localparam int CLEAR_ALL_BIT = 31;

    function automatic logic [2:0] reg_sel(input logic [4:0] addr);
        return addr[4:2];
    endfunction

endpackage : munoc_monitor_pkg

// File: rtl/munoc_monitor_sticky_bank.sv
// -----------------------------------------------------------------------------
// munoc_monitor_sticky_bank
//
// Per-flag state of the status collector: sticky bits, the registered copy of
// the previous monitor vector, rising-edge detection and a lowest-index
// priority encoder over the live flag vector.
//
// Ports:
//   clk         clock
//   rstnn       synchronous active-low reset
//   enable_i    capture enable; when low, sticky and previous-flags hold
//   flags_i     live monitor flag vector
//   clr_i       per-bit sticky clear (honoured regardless of enable_i)
//   sticky_o    sticky flag bits
//   rise_o      flags that are high now but were low at the previous capture
//   any_flag_o  at least one live flag is set
//   low_idx_o   index of the lowest set live flag (0 when none)
// -----------------------------------------------------------------------------
module munoc_monitor_sticky_bank
    import munoc_monitor_pkg::*;
#(
    parameter int NUM_FLAGS = 13
) (
    input  logic                   clk,
    input  logic                   rstnn,
    input  logic                   enable_i,
    input  logic [NUM_FLAGS-1:0]   flags_i,
    input  logic [NUM_FLAGS-1:0]   clr_i,
    output logic [NUM_FLAGS-1:0]   sticky_o,
    output logic [NUM_FLAGS-1:0]   rise_o,
    output logic                   any_flag_o,
    output logic [FIRST_IDX_W-1:0] low_idx_o
);

    logic [NUM_FLAGS-1:0] sticky_q, sticky_d;
    logic [NUM_FLAGS-1:0] prev_q, prev_d;

    // Clear is applied first so a flag raised in the same cycle wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; that is what keeps latches from being inferred.
        sticky_d = sticky_q & ~clr_i;
        prev_d   = prev_q;
        if (enable_i) begin
            sticky_d = sticky_d | flags_i;
            prev_d   = flags_i;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        if (!rstnn) begin
            sticky_q <= '0;
            prev_q   <= '0;
        end else begin
            sticky_q <= sticky_d;
            prev_q   <= prev_d;
        end
    end

    assign sticky_o   = sticky_q;
    assign rise_o     = flags_i & ~prev_q;
    assign any_flag_o = |flags_i;

    // Scan from the top down so the last hit, i.e. the lowest index, sticks.
    always_comb begin
        low_idx_o = '0;
        for (int i = NUM_FLAGS - 1; i >= 0; i--) begin
            if (flags_i[i]) begin
                low_idx_o = FIRST_IDX_W'(i);
            end
        end
    end

endmodule : munoc_monitor_sticky_bank

// File: rtl/munoc_monitor_status_collector.sv
// -----------------------------------------------------------------------------
// munoc_monitor_status_collector
//
// Makes the per-channel AXI protocol-monitor flag vector software-visible:
// sticky flags, first-offender capture, saturating count of new events and a
// maskable registered level interrupt, all behind a zero-wait APB slave.
//
// Optional feature macro: MUNOC_MONITOR_TIMESTAMP_EN
//   defined   -> free-running 32-bit cycle counter (advances on enable=1
//                cycles), latched into TIMESTAMP when FIRST is captured.
//   undefined -> no counter; TIMESTAMP reads 0.
//
// Ports:
//   clk, rstnn      clock, synchronous active-low reset
//   enable          capture enable (APB access works regardless)
//   monitor_flags   live flags from the monitor, bit 0 = LSB
//   psel/penable/pwrite/paddr/pwdata  APB request
//   prdata          read data, 0 outside a read access phase
//   pready          always 1 (zero wait states)
//   pslverr         read of an unmapped offset (0x18, 0x1C)
//   interrupt       registered |(sticky & mask)
//
// Register map: 0x00 STATUS(ro) 0x04 CLEAR(wo) 0x08 MASK(rw) 0x0C FIRST(ro)
//               0x10 TIMESTAMP(ro) 0x14 EVENT_COUNT(ro)
// -----------------------------------------------------------------------------
module munoc_monitor_status_collector
    import munoc_monitor_pkg::*;
#(
    parameter int NUM_FLAGS      = 13,
    parameter int BW_EVENT_COUNT = 16
) (
    input  logic                 clk,
    input  logic                 rstnn,
    input  logic                 enable,
    input  logic [NUM_FLAGS-1:0] monitor_flags,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [4:0]           paddr,
    input  logic [31:0]          pwdata,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic                 interrupt
);

    localparam logic [BW_EVENT_COUNT-1:0] CNT_MAX = '1;

    // ---------------------------------------------------------------- APB ---
    logic       wr_en, rd_en;
    logic [2:0] sel;
    logic       wr_clear, wr_mask;
    logic [NUM_FLAGS-1:0] clr_bits;
    logic       clr_all;

    assign wr_en    = psel & penable & pwrite;
    assign rd_en    = psel & penable & ~pwrite;
    assign sel      = reg_sel(paddr);
    assign wr_clear = wr_en && (sel == reg_sel(OFF_CLEAR));
    assign wr_mask  = wr_en && (sel == reg_sel(OFF_MASK));
    assign clr_bits = wr_clear ? pwdata[NUM_FLAGS-1:0] : '0;
    assign clr_all  = wr_clear & pwdata[CLEAR_ALL_BIT];
    assign pready   = 1'b1;

    // ------------------------------------------------------- sticky bank ---
    logic [NUM_FLAGS-1:0]   sticky, rise;
    logic                   any_flag;
    logic [FIRST_IDX_W-1:0] low_idx;

    munoc_monitor_sticky_bank #(
        .NUM_FLAGS (NUM_FLAGS)
    ) u_sticky_bank (
        .clk        (clk),
        .rstnn      (rstnn),
        .enable_i   (enable),
        .flags_i    (monitor_flags),
        .clr_i      (clr_bits),
        .sticky_o   (sticky),
        .rise_o     (rise),
        .any_flag_o (any_flag),
        .low_idx_o  (low_idx)
    );

    // ----------------------------------------------- mask, FIRST, counter ---
    logic [NUM_FLAGS-1:0]      mask_q, mask_d;
    logic                      first_valid_q, first_valid_d;
    logic [FIRST_IDX_W-1:0]    first_idx_q, first_idx_d;
    logic [BW_EVENT_COUNT-1:0] cnt_q, cnt_d, cnt_base;
    logic                      irq_q, irq_d;
    logic                      capture;

    // A clear of FIRST is applied before the capture test, so a flag in the
    // same cycle as CLEAR[31] recaptures immediately.
    assign capture = enable & ~(first_valid_q & ~clr_all) & any_flag;

    always_comb begin
        mask_d        = wr_mask ? pwdata[NUM_FLAGS-1:0] : mask_q;

        first_valid_d = first_valid_q & ~clr_all;
        first_idx_d   = clr_all ? '0 : first_idx_q;
        if (capture) begin
            first_valid_d = 1'b1;
            first_idx_d   = low_idx;
        end

        // One increment per cycle with any rising flag, not per flag.
        cnt_base = clr_all ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (enable && (|rise) && (cnt_base != CNT_MAX)) begin
            cnt_d = cnt_base + BW_EVENT_COUNT'(1);
        end

        irq_d = |(sticky & mask_q);
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            mask_q        <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            cnt_q         <= '0;
            irq_q         <= 1'b0;
        end else begin
            mask_q        <= mask_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
            cnt_q         <= cnt_d;
            irq_q         <= irq_d;
        end
    end

    assign interrupt = irq_q;

    // ---------------------------------------------------------- timestamp ---
    logic [31:0] timestamp;

`ifdef MUNOC_MONITOR_TIMESTAMP_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] ts_q, ts_d;

    // The free-running counter is never touched by CLEAR; only TIMESTAMP is.
    always_comb begin
        cycle_d = enable ? cycle_q + 32'd1 : cycle_q;
        ts_d    = clr_all ? 32'd0 : ts_q;
        if (capture) begin
            ts_d = cycle_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            cycle_q <= '0;
            ts_q    <= '0;
        end else begin
            cycle_q <= cycle_d;
            ts_q    <= ts_d;
        end
    end

    assign timestamp = ts_q;
`else
    assign timestamp = 32'd0;
`endif

    // ---------------------------------------------------------- read mux ---
    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (rd_en) begin
            case (sel)
                reg_sel(OFF_STATUS):      prdata = 32'(sticky);
                reg_sel(OFF_CLEAR):       prdata = '0;
                reg_sel(OFF_MASK):        prdata = 32'(mask_q);
                reg_sel(OFF_FIRST): begin
                    prdata[FIRST_VALID_BIT]   = first_valid_q;
                    prdata[FIRST_IDX_W-1:0]   = first_idx_q;
                end
                reg_sel(OFF_TIMESTAMP):   prdata = timestamp;
                reg_sel(OFF_EVENT_COUNT): prdata = 32'(cnt_q);
                default:                  pslverr = 1'b1;
            endcase
        end
    end

    // Address byte-lane bits and the upper write-data bits carry no meaning.
    logic unused_ok;
    assign unused_ok = ^{paddr[1:0], pwdata};

endmodule : munoc_monitor_status_collector

// File: tb/tb_munoc_monitor_status_collector.sv
// -----------------------------------------------------------------------------
// Self-checking bench for munoc_monitor_status_collector.
// Reads push their expected {pslverr, prdata} into a scoreboard queue; a
// monitor pops and compares whenever an APB read access phase is on the bus,
// and compares the interrupt pin against the reference model every cycle.
// -----------------------------------------------------------------------------
module tb_munoc_monitor_status_collector;

    localparam int NF   = 13;
    localparam int BW   = 4;
    localparam int CMAX = (1 << BW) - 1;

    logic          clk = 1'b0;
    logic          rstnn = 1'b0;
    logic          enable = 1'b1;
    logic [NF-1:0] monitor_flags = '0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [4:0]    paddr = '0;
    logic [31:0]   pwdata = '0;
    logic [31:0]   prdata;
    logic          pready, pslverr, interrupt;

    munoc_monitor_status_collector #(
        .NUM_FLAGS      (NF),
        .BW_EVENT_COUNT (BW)
    ) dut (
        .clk           (clk),
        .rstnn         (rstnn),
        .enable        (enable),
        .monitor_flags (monitor_flags),
        .psel          (psel),
        .penable       (penable),
        .pwrite        (pwrite),
        .paddr         (paddr),
        .pwdata        (pwdata),
        .prdata        (prdata),
        .pready        (pready),
        .pslverr       (pslverr),
        .interrupt     (interrupt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ checking ---
    int n_checks = 0;
    int n_pass   = 0;
    bit check_irq = 1'b0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        string       name;
        logic [32:0] val;   // {pslverr, prdata}
    } exp_t;
    exp_t exp_q[$];

    // ----------------------------------------------------- reference model ---
    logic [NF-1:0] m_sticky, m_mask, m_prev;
    bit            m_fv, m_int;
    int            m_fidx, m_cnt;
    logic [31:0]   m_ts, m_free;

    function automatic int lowest(input logic [NF-1:0] f);
        for (int i = 0; i < NF; i++) if (f[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        bit            wr, clr_all;
        logic [NF-1:0] clr;
        if (!rstnn) begin
            m_sticky = '0; m_mask = '0; m_prev = '0; m_fv = 0; m_int = 0;
            m_fidx = 0; m_cnt = 0; m_ts = '0; m_free = '0;
        end else begin
            m_int   = (m_sticky & m_mask) != '0;
            wr      = psel && penable && pwrite;
            clr     = (wr && paddr[4:2] == 3'd1) ? pwdata[NF-1:0] : '0;
            clr_all = wr && paddr[4:2] == 3'd1 && pwdata[31];
            if (wr && paddr[4:2] == 3'd2) m_mask = pwdata[NF-1:0];
            m_sticky = m_sticky & ~clr;
            if (clr_all) begin
                m_fv = 0; m_fidx = 0; m_ts = '0; m_cnt = 0;
            end
            if (enable) begin
                m_sticky = m_sticky | monitor_flags;
                if ((monitor_flags & ~m_prev) != '0 && m_cnt < CMAX) m_cnt++;
                if (!m_fv && monitor_flags != '0) begin
                    m_fv   = 1;
                    m_fidx = lowest(monitor_flags);
`ifdef MUNOC_MONITOR_TIMESTAMP_EN
                    m_ts   = m_free;
`endif
                end
                m_prev = monitor_flags;
                m_free = m_free + 32'd1;
            end
        end
    end

    function automatic logic [32:0] model_read(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return {1'b0, 32'(m_sticky)};
            3'd1:    return 33'd0;
            3'd2:    return {1'b0, 32'(m_mask)};
            3'd3:    return {1'b0, m_fv, 23'd0, 8'(m_fidx)};
            3'd4:    return {1'b0, m_ts};
            3'd5:    return {1'b0, 32'(m_cnt)};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // ------------------------------------------------------------- monitor ---
    always @(negedge clk) begin
        if (rstnn && psel && penable && !pwrite) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", {pslverr, prdata}, 33'h1_dead_beef);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, {pslverr, prdata}, e.val);
            end
        end
        if (check_irq) check("interrupt_vs_model", {32'd0, interrupt}, {32'd0, m_int});
    end

    // ------------------------------------------------------------- drivers ---
    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // use_model=1 takes the expectation from the model, else from exp_val.
    task automatic apb_read(input logic [4:0] a, input bit use_model,
                            input logic [32:0] exp_val, input string name);
        exp_t e;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        e.name = name;
        e.val  = use_model ? model_read(a) : exp_val;
        exp_q.push_back(e);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstnn = 1'b0; monitor_flags = '0;
        @(posedge clk); #1;
        rstnn = 1'b1;
    endtask

    task automatic read_all_zero(input string tag);
        for (int r = 0; r < 6; r++) apb_read(5'(r * 4), 0, 33'd0, $sformatf("%s_reg%0d", tag, r));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    bit rand_run;

    initial begin
        repeat (3) @(posedge clk);
        #1 rstnn = 1'b1;
        check_irq = 1'b1;

        // Post-reset state.
        check("pready", {32'd0, pready}, 33'd1);
        read_all_zero("reset");
        apb_read(5'h18, 0, {1'b1, 32'd0}, "unmapped_0x18");
        apb_read(5'h1C, 0, {1'b1, 32'd0}, "unmapped_0x1C");

        // Single pulse on flag 2 with mask bit 2 set.
        apb_write(5'h08, 32'h0000_0004);
        @(posedge clk); #1 monitor_flags = 13'h0004;
        @(posedge clk); #1 monitor_flags = '0;
        check("irq_one_edge_after_pulse", {32'd0, interrupt}, 33'd0);
        @(posedge clk); #1;
        check("irq_two_edges_after_pulse", {32'd0, interrupt}, 33'd1);
        apb_read(5'h00, 0, 33'h0_0000_0004, "status_pulse");
        apb_read(5'h0C, 0, 33'h0_8000_0002, "first_pulse");
        apb_read(5'h14, 0, 33'd1, "count_pulse");
        apb_write(5'h04, 32'h0000_0004);
        check("irq_at_clear_edge", {32'd0, interrupt}, 33'd1);
        @(posedge clk); #1;
        check("irq_after_clear", {32'd0, interrupt}, 33'd0);
        apb_read(5'h00, 0, 33'd0, "status_cleared");

        // Set beats clear on the same bit in the same cycle.
        @(posedge clk); #1 monitor_flags = 13'h0020;
        apb_write(5'h04, 32'h0000_0020);
        apb_read(5'h00, 0, 33'h0_0000_0020, "status_set_wins");
        monitor_flags = '0;
        apb_write(5'h04, 32'h8000_1FFF);

        // Priority encode and one count per rising cycle.
        @(posedge clk); #1 monitor_flags = 13'h0050;
        @(posedge clk); #1 monitor_flags = 13'h0051;
        @(posedge clk); #1 monitor_flags = '0;
        apb_read(5'h0C, 0, 33'h0_8000_0004, "first_priority");
        apb_read(5'h14, 0, 33'd2, "count_priority");
        apb_read(5'h10, 1, 33'd0, "timestamp_priority");
        apb_write(5'h04, 32'h8000_0000);
        apb_read(5'h0C, 0, 33'd0, "first_after_clear_all");
        apb_read(5'h14, 0, 33'd0, "count_after_clear_all");

        // Saturation of the 4-bit counter.
        for (int p = 0; p < 20; p++) begin
            @(posedge clk); #1 monitor_flags = 13'h0002;
            @(posedge clk); #1 monitor_flags = '0;
        end
        apb_read(5'h14, 0, 33'd15, "count_saturated");

        // Capture disabled.
        apb_write(5'h04, 32'h8000_1FFF);
        @(posedge clk); #1 enable = 1'b0; monitor_flags = 13'h0001;
        repeat (3) @(posedge clk);
        apb_read(5'h00, 0, 33'd0, "status_enable_low");
        apb_read(5'h0C, 0, 33'd0, "first_enable_low");
        monitor_flags = '0; enable = 1'b1;

        // Randomized traffic against the model.
        rand_run = 1'b1;
        fork
            begin
                while (rand_run) begin
                    @(posedge clk); #1;
                    enable = ($urandom_range(0, 7) != 0);
                    if ($urandom_range(0, 3) == 0)
                        monitor_flags = NF'(1 << $urandom_range(0, NF - 1)) |
                                        (($urandom_range(0, 3) == 0) ? NF'($urandom) : '0);
                    else if ($urandom_range(0, 1) == 0)
                        monitor_flags = '0;
                end
            end
            begin
                for (int k = 0; k < 300; k++) begin
                    case ($urandom_range(0, 9))
                        0: apb_write(5'h04 | 5'($urandom_range(0, 3)), $urandom);
                        1: apb_write(5'h08, $urandom);
                        2: apb_write(5'($urandom_range(0, 31)), $urandom);
                        default: begin
                            logic [4:0] a;
                            a = 5'($urandom_range(0, 31));
                            apb_read(a, 1, 33'd0, $sformatf("rand_rd_0x%0h", a));
                        end
                    endcase
                end
                rand_run = 1'b0;
            end
        join
        @(posedge clk); #1 enable = 1'b1; monitor_flags = '0;

        // Reset in the middle of activity.
        apb_write(5'h08, 32'h0000_1FFF);
        @(posedge clk); #1 monitor_flags = 13'h0003;
        repeat (3) @(posedge clk);
        #1 check("irq_before_midreset", {32'd0, interrupt}, 33'd1);
        do_reset();
        check("irq_after_midreset", {32'd0, interrupt}, 33'd0);
        read_all_zero("midreset");

        // Timestamp after exactly 100 enabled cycles from reset.
        do_reset();
        repeat (100) @(posedge clk);
        #1 monitor_flags = 13'h0001;
        @(posedge clk); #1 monitor_flags = '0;
`ifdef MUNOC_MONITOR_TIMESTAMP_EN
        apb_read(5'h10, 0, 33'd100, "timestamp_100");
`else
        apb_read(5'h10, 0, 33'd0, "timestamp_absent");
`endif
        apb_read(5'h0C, 0, 33'h0_8000_0000, "first_ts");

        repeat (4) @(posedge clk);
        #1 check("scoreboard_drained", 33'(exp_q.size()), 33'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_munoc_monitor_status_collector
